// File: rtl/mult_controller_pkg.sv
// Shared CPU encodings: ALU op, result-select and multiplier FSM states.
// Ports: none (package). Default multiplier operand width lives here as well
// so decode, datapath and the multiplier agree on one value.
package mult_controller_pkg;

  localparam int MULT_WIDTH = 32;

  // Multiplier sequencing: IDLE waits for a request, RUN does one
  // shift-add step per cycle, FIX applies the sign and writes hi/lo.
  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_FIX  = 2'd2
  } mult_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    OUT_ALU   = 2'd0,
    OUT_SHIFT = 2'd1,
    OUT_HI    = 2'd2,
    OUT_LO    = 2'd3
  } out_select_e;

endpackage

// File: rtl/mult_shift_add.sv
// One radix-2 shift-add multiply step, purely combinational.
// Ports: acc_in/acc_out = 2*WIDTH partial product, mcand = multiplicand,
// add_en = current multiplier LSB (add mcand into the upper half first).
module mult_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               add_en,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] wide;

  always_comb begin
    upper_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    if (add_en) begin
      upper_sum = upper_sum + {1'b0, mcand};
    end
    // The carry out of the upper add becomes the new MSB after the shift.
    wide    = {upper_sum, acc_in[WIDTH-1:0]};
    acc_out = (2*WIDTH)'(wide >> 1);
  end

endmodule

// File: rtl/mult_controller.sv
// Multi-cycle hi/lo multiplier for mult/multu: WIDTH RUN cycles + 1 FIX cycle.
// Ports: start_mult/mult_sign/srca/srcb request, rd_hilo/flush from the pipe,
// busy/stall/done status, hi/lo registered product words.
module mult_controller
  import mult_controller_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] fixed;

  mult_shift_add #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .mcand   (mcand_q),
    .add_en  (mplr_q[0]),
    .acc_out (step_acc)
  );

  always_comb begin
    // Signed operands are multiplied as magnitudes; the most-negative value
    // negates to itself, which is the correct unsigned magnitude.
    mag_a = (mult_sign && srca[WIDTH-1]) ? -srca : srca;
    mag_b = (mult_sign && srcb[WIDTH-1]) ? -srcb : srcb;
    fixed = neg_q ? -acc_q : acc_q;

    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      MULT_IDLE: begin
        // flush beats a same-cycle start request.
        if (start_mult && !flush) begin
          mcand_d = mag_a;
          mplr_d  = mag_b;
          neg_d   = mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = MULT_RUN;
          busy_d  = 1'b1;
        end
      end
      MULT_RUN: begin
        if (flush) begin
          state_d = MULT_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d  = step_acc;
          mplr_d = mplr_q >> 1;
          if (cnt_q == '0) begin
            state_d = MULT_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      MULT_FIX: begin
        if (flush) begin
          state_d = MULT_IDLE;
          busy_d  = 1'b0;
        end else begin
          {hi_d, lo_d} = fixed;
          state_d      = MULT_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
      end
      default: begin
        state_d = MULT_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MULT_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Freeze decode while a hi/lo read would see a stale or pending result.
  assign stall = rd_hilo & (busy_q | start_mult);

endmodule

// File: tb/tb_mult_controller.sv
module tb_mult_controller;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        rd_hilo;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  int done_count;
  logic [63:0] exp_q[$];

  mult_controller #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .srca       (srca),
    .srcb       (srcb),
    .rd_hilo    (rd_hilo),
    .flush      (flush),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; the result itself is checked by the monitor.
  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", {63'd0, seen}, 64'd1);
    next_cycle();
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back({eh, el});
    start_mult = 1'b1;
    mult_sign  = sgn;
    srca       = a;
    srcb       = b;
    next_cycle();
    start_mult = 1'b0;
    wait_done();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    done_count = 0;
    reset      = 1'b0;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    srca       = '0;
    srcb       = '0;
    rd_hilo    = 1'b0;
    flush      = 1'b0;

    // Scoreboard monitor: every done pulse pops one expected {hi,lo}.
    fork
      forever begin
        @(negedge clk);
        if (reset && done) begin
          done_count++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no done", hi, lo);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
              fails++;
              $display("FAIL result: got 0x%0h_%0h expected 0x%0h", hi, lo, e);
            end
          end
        end
      end
    join_none

    repeat (3) next_cycle();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    next_cycle();

    // Latency/stall profile of multu 3 x 5 with a second start at cycle 5.
    exp_q.push_back({32'h0, 32'hF});
    rd_hilo = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      start_mult = (c == 0) || (c == 5);
      mult_sign  = 1'b0;
      srca       = (c == 0) ? 32'd3 : 32'd7;
      srcb       = (c == 0) ? 32'd5 : 32'd7;
      @(negedge clk);
      check($sformatf("busy_c%0d", c), {63'd0, busy}, {63'd0, (c >= 1 && c <= 33)});
      check($sformatf("stall_c%0d", c), {63'd0, stall}, {63'd0, (c <= 33)});
      check($sformatf("done_c%0d", c), {63'd0, done}, {63'd0, (c == 34)});
      next_cycle();
    end
    start_mult = 1'b0;
    rd_hilo    = 1'b0;

    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(1'b1, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC);
    run_op(1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    run_op(1'b1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000);
    // Leaves hi/lo = 0x1/0x2 for the abort tests.
    run_op(1'b0, 32'h80000001, 32'h00000002, 32'h00000001, 32'h00000002);

    // Flush in cycle 10 aborts the operation.
    begin
      int dc0;
      dc0 = done_count;
      for (int c = 0; c <= 12; c++) begin
        start_mult = (c == 0);
        srca       = 32'd3;
        srcb       = 32'd5;
        flush      = (c == 10);
        @(negedge clk);
        if (c == 10) check("flush_busy_c10", {63'd0, busy}, 64'd1);
        if (c == 11) check("flush_busy_c11", {63'd0, busy}, 64'd0);
        next_cycle();
      end
      start_mult = 1'b0;
      flush      = 1'b0;
      repeat (40) next_cycle();
      check("flush_no_done", 64'(done_count - dc0), 64'd0);
      check("flush_hilo", {hi, lo}, {32'h1, 32'h2});

      // start_mult and flush together in IDLE: nothing starts.
      start_mult = 1'b1;
      flush      = 1'b1;
      next_cycle();
      start_mult = 1'b0;
      flush      = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", {63'd0, busy}, 64'd0);
      repeat (40) next_cycle();
      check("idle_flush_no_done", 64'(done_count - dc0), 64'd0);
      check("idle_flush_hilo", {hi, lo}, {32'h1, 32'h2});
    end

    // Asynchronous reset in the middle of cycle 20 of an operation.
    start_mult = 1'b1;
    srca       = 32'd7;
    srcb       = 32'd9;
    next_cycle();
    start_mult = 1'b0;
    repeat (19) next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    repeat (2) next_cycle();
    reset = 1'b1;
    exp_q.push_back({32'h0, 32'h4});
    start_mult = 1'b1;
    mult_sign  = 1'b0;
    srca       = 32'd2;
    srcb       = 32'd2;
    next_cycle();
    start_mult = 1'b0;
    check("post_rst_busy", {63'd0, busy}, 64'd1);
    wait_done();

    repeat (3) next_cycle();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
